// File: rtl/mux_pipe_stage.sv
// Select-and-capture pipeline stage: an N:1 mux feeding a two-entry skid buffer
// with a registered in_ready, flush, and out-of-range select error tracking.
module mux_pipe_stage #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  output logic [7:0]              err_cnt
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             sel_err_q, sel_err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0] sel_word;
  logic             sel_oor;
  logic             accept;
  logic             consume;
  logic             valid_int;

  // Out-of-range selects fall through with a zero word and sel_oor still set.
  always_comb begin
    sel_word = '0;
    sel_oor  = 1'b1;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_word = in_data[k*WIDTH +: WIDTH];
        sel_oor  = 1'b0;
      end
    end
  end

  assign valid_int = (state_q != StEmpty);
  assign accept    = in_valid && in_ready_q && !flush;
  assign consume   = valid_int && out_ready && !flush;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      state_d = StEmpty;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            main_d  = sel_word;
            state_d = StOne;
          end
        end
        StOne: begin
          if (accept && consume) begin
            main_d = sel_word;
          end else if (accept) begin
            skid_d  = sel_word;
            state_d = StTwo;
          end else if (consume) begin
            main_d  = '0;
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (consume) begin
            main_d  = skid_q;
            skid_d  = '0;
            state_d = StOne;
          end
        end
        default: begin
          state_d = StEmpty;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end

    // Computed from the next state so in_ready never depends on out_ready this cycle.
    in_ready_d = (state_d != StTwo);
  end

  // Error tracking survives flush; only reset clears it.
  always_comb begin
    sel_err_d = sel_err_q;
    err_cnt_d = err_cnt_q;
    if (accept && sel_oor) begin
      sel_err_d = 1'b1;
      if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      sel_err_q  <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      sel_err_q  <= sel_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = valid_int;
  assign out_data  = valid_int ? main_q : '0;
  assign sel_err   = sel_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_mux_pipe_stage.sv
// Bench for mux_pipe_stage: scoreboard queue filled on modelled accepts and drained
// on consumes, plus per-scenario directed checks.
module tb_mux_pipe_stage;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned NUM_IN = 4;
  localparam int unsigned SEL_W  = 3;

  logic                    clk;
  logic                    rst_n;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;
  logic [7:0]              err_cnt;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;
  logic [WIDTH-1:0] sb_q[$];

  mux_pipe_stage #(
    .WIDTH (WIDTH),
    .NUM_IN(NUM_IN),
    .SEL_W (SEL_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .flush    (flush),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sel_err  (sel_err),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  function automatic logic [WIDTH-1:0] model_pick(logic [NUM_IN*WIDTH-1:0] d, logic [SEL_W-1:0] s);
    if (s < NUM_IN) return d[s*WIDTH +: WIDTH];
    return '0;
  endfunction

  // Scoreboard monitor: outputs sampled mid-cycle, queue models the stage contents.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      logic exp_ready;
      exp_ready = (sb_q.size() < 2);
      total++;
      if (in_ready !== exp_ready) begin
        bad++;
        $display("FAIL sb_in_ready: got %b want %b (depth %0d)", in_ready, exp_ready, sb_q.size());
      end
      total++;
      if (out_valid !== (sb_q.size() != 0)) begin
        bad++;
        $display("FAIL sb_out_valid: got %b want %b", out_valid, sb_q.size() != 0);
      end else if (sb_q.size() != 0) begin
        total++;
        if (out_data !== sb_q[0]) begin
          bad++;
          $display("FAIL sb_head: got %h want %h", out_data, sb_q[0]);
        end
      end else begin
        total++;
        if (out_data !== '0) begin
          bad++;
          $display("FAIL sb_idle_zero: got %h want 0", out_data);
        end
      end
      if (flush) begin
        sb_q.delete();
      end else begin
        if (out_ready && sb_q.size() != 0) void'(sb_q.pop_front());
        if (in_valid && exp_ready) sb_q.push_back(model_pick(in_data, in_sel));
      end
    end else if (!rst_n) begin
      sb_q.delete();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    flush     = 1'b0;
    in_sel    = '0;
    in_data   = '0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    out_ready = 1'b0;
    idle_inputs();
    step();
    step();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
      bad++;
      $display("FAIL reset_out: got valid=%b ready=%b data=%h want 0/1/0", out_valid, in_ready, out_data);
    end
    total++;
    if (sel_err !== 1'b0 || err_cnt !== 8'd0) begin
      bad++;
      $display("FAIL reset_err: got sel_err=%b err_cnt=%0d want 0/0", sel_err, err_cnt);
    end
    rst_n  = 1'b1;
    mon_en = 1'b1;
    step();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    in_data   = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    in_sel    = 3'd2;
    in_valid  = 1'b1;
    step();
    idle_inputs();
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'hCCCC_CCCC) begin
      bad++;
      $display("FAIL basic_latency: got valid=%b data=%h want 1/cccccccc", out_valid, out_data);
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_drain: got valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_two();
    out_ready = 1'b0;
    in_sel    = 3'd0;
    in_valid  = 1'b1;
    in_data   = '0;
    in_data[31:0] = 32'h11;
    step();
    in_data[31:0] = 32'h22;
    step();
    idle_inputs();
    total++;
    if (in_ready !== 1'b0 || out_data !== 32'h11) begin
      bad++;
      $display("FAIL two_full: got ready=%b data=%h want 0/11", in_ready, out_data);
    end
    step();
    total++;
    if (out_data !== 32'h11 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL two_hold: got valid=%b data=%h want 1/11", out_valid, out_data);
    end
    out_ready = 1'b1;
    step();
    total++;
    if (out_data !== 32'h22 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL two_first_pop: got data=%h ready=%b want 22/1", out_data, in_ready);
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL two_empty: got valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int ready_low = 0;
    out_ready = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      in_data  = {NUM_IN{32'hFFFF_FFFF}};
      in_sel   = SEL_W'(i % NUM_IN);
      in_data[(i % NUM_IN)*WIDTH +: WIDTH] = i;
      in_valid = 1'b1;
      step();
      if (in_ready !== 1'b1) ready_low++;
      if (out_valid !== 1'b1 || out_data !== 32'(i)) begin
        bad++;
        $display("FAIL b2b_word: got valid=%b data=%h want 1/%h", out_valid, out_data, i);
      end
      total++;
    end
    idle_inputs();
    total++;
    if (ready_low != 0) begin
      bad++;
      $display("FAIL b2b_ready: in_ready low %0d cycles, want 0", ready_low);
    end
    step();
    total++;
    if (out_valid !== 1'b0 || sb_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_drain: got valid=%b left=%0d want 0/0", out_valid, sb_q.size());
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 3'd1;
    in_data   = '0;
    in_data[63:32] = 32'h0000_0A01;
    step();
    in_data[63:32] = 32'h0000_0A02;
    step();
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_pre: got ready=%b want 0", in_ready);
    end
    in_sel          = 3'd3;
    in_data[127:96] = 32'hDEAD_BEEF;
    flush           = 1'b1;
    step();
    idle_inputs();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
      bad++;
      $display("FAIL flush_after: got valid=%b ready=%b data=%h want 0/1/0", out_valid, in_ready, out_data);
    end
    out_ready = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_absent: got valid=%b data=%h want 0", out_valid, out_data);
    end
  endtask

  task automatic test_sel_err();
    out_ready = 1'b1;
    in_data   = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    in_sel    = 3'd5;
    in_valid  = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (i == 10) begin
        total++;
        if (err_cnt !== 8'd10 || sel_err !== 1'b1) begin
          bad++;
          $display("FAIL sel_err_mid: got cnt=%0d err=%b want 10/1", err_cnt, sel_err);
        end
      end
    end
    idle_inputs();
    total++;
    if (sel_err !== 1'b1 || err_cnt !== 8'd255) begin
      bad++;
      $display("FAIL sel_err_sat: got err=%b cnt=%0d want 1/255", sel_err, err_cnt);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++;
    if (sel_err !== 1'b1 || err_cnt !== 8'd255) begin
      bad++;
      $display("FAIL sel_err_flush: got err=%b cnt=%0d want 1/255", sel_err, err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_sel    = 3'd1;
    in_data   = {32'h0, 32'h0, 32'h0000_5A5A, 32'h0};
    in_valid  = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'h0000_5A5A) begin
      bad++;
      $display("FAIL rstmid_pre: got valid=%b data=%h want 1/5a5a", out_valid, out_data);
    end
    rst_n     = 1'b0;
    flush     = 1'b1;
    out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    idle_inputs();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sel_err !== 1'b0 || err_cnt !== 8'd0) begin
      bad++;
      $display("FAIL rstmid_after: got valid=%b ready=%b err=%b cnt=%0d want 0/1/0/0",
               out_valid, in_ready, sel_err, err_cnt);
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_gone: got valid=%b want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_two();
    test_back_to_back();
    test_flush();
    test_sel_err();
    test_reset_mid();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
